// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin UART transmitter: grants one byte at a time and sends it as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_arbiter #(
   parameter int unsigned CLK_DIV = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       tx,
   output logic       busy,
   output logic       owner
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shreg, shreg_n;
   logic        last, last_n;
   logic        tx_n, busy_n, gnt0_n, gnt1_n, owner_n;
   logic        win;
   logic        bit_done;

   assign bit_done = (cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         last    <= 1'b1;
         tx      <= 1'b1;
         busy    <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         owner   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         last    <= last_n;
         tx      <= tx_n;
         busy    <= busy_n;
         gnt0    <= gnt0_n;
         gnt1    <= gnt1_n;
         owner   <= owner_n;
      end
   end

   // The shift register stays unshifted; bit_idx selects the bit on the line.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 16'd1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      last_n    = last;
      tx_n      = tx;
      busy_n    = busy;
      gnt0_n    = 1'b0;
      gnt1_n    = 1'b0;
      owner_n   = owner;
      win       = (req0 && req1) ? ~last : req1;
      case (state)
         IDLE: begin
            cnt_n  = '0;
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (req0 || req1) begin
               shreg_n   = win ? data1 : data0;
               owner_n   = win;
               last_n    = win;
               gnt0_n    = ~win;
               gnt1_n    = win;
               tx_n      = 1'b0;
               busy_n    = 1'b1;
               bit_idx_n = '0;
               state_n   = START;
            end
         end
         START: begin
            if (bit_done) begin
               cnt_n   = '0;
               tx_n    = shreg[0];
               state_n = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                  tx_n    = ^shreg;
                  state_n = PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = shreg[bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               cnt_n   = '0;
               tx_n    = 1'b1;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               cnt_n   = '0;
               tx_n    = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            cnt_n   = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based frame model checked every cycle, plus directed scenarios.
module tb_uart_tx_arbiter;

   localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk, rst_n;
   logic       req0, req1, gnt0, gnt1, tx, busy, owner;
   logic [7:0] data0, data1;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_arbiter #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .tx(tx), .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Frame as transmitted, index 0 first on the line.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      frame_of = {1'b1, ^d, d, 1'b0};
`else
      frame_of = {1'b0, 1'b1, d, 1'b0};
`endif
   endfunction

   // ---------------- reference model ----------------
   logic m_tx, m_busy, m_g0, m_g1, m_owner, m_last;
   logic m_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_tx = 1'b1; m_busy = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;
         m_owner = 1'b0; m_last = 1'b1;
      end else begin
         logic w;
         logic [10:0] f;
         m_g0 = 1'b0;
         m_g1 = 1'b0;
         if (!m_busy && (req0 || req1)) begin
            w = (req0 && req1) ? !m_last : req1;
            f = frame_of(w ? data1 : data0);
            for (int k = 0; k < NB; k++)
               for (int c = 0; c < CD; c++) m_q.push_back(f[k]);
            m_owner = w;
            m_last  = w;
            if (w) m_g1 = 1'b1; else m_g0 = 1'b1;
         end
         if (m_q.size() > 0) begin
            m_tx = m_q.pop_front();
            m_busy = 1'b1;
         end else begin
            m_tx = 1'b1;
            m_busy = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      check("cycle_outputs", {27'd0, tx, busy, gnt0, gnt1, owner},
            {27'd0, m_tx, m_busy, m_g0, m_g1, m_owner});
   end

   // ---------------- monitor ----------------
   int          gnt0_cnt, gnt1_cnt, busy_run, idle_run;
   logic        prev_busy, have_frame;
   logic [10:0] cur_bits;
   int          len_q[$], gap_q[$];
   logic [10:0] frame_q[$];
   logic        gnt_q[$];

   task automatic clear_mon();
      gnt0_cnt = 0; gnt1_cnt = 0; busy_run = 0; idle_run = 0;
      prev_busy = 1'b0; have_frame = 1'b0; cur_bits = '0;
      len_q.delete(); gap_q.delete(); frame_q.delete(); gnt_q.delete();
   endtask

   always @(posedge clk) begin
      #2;
      if (gnt0) gnt0_cnt++;
      if (gnt1) gnt1_cnt++;
      if (gnt0 || gnt1) gnt_q.push_back(gnt1);
      if (busy) begin
         if (!prev_busy) begin
            if (have_frame) gap_q.push_back(idle_run);
            busy_run = 0;
            cur_bits = '0;
         end
         if ((busy_run % CD) == CD / 2 && (busy_run / CD) < 11) cur_bits[busy_run / CD] = tx;
         busy_run++;
      end else begin
         if (prev_busy) begin
            len_q.push_back(busy_run);
            frame_q.push_back(cur_bits);
            have_frame = 1'b1;
            idle_run = 0;
         end
         idle_run++;
      end
      prev_busy = busy;
   end

   // ---------------- driver helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
   endtask

   task automatic wait_gnt(input int limit);
      int n = 0;
      while (!(gnt0 || gnt1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("gnt_wait", {31'd0, gnt0 || gnt1}, 32'd1);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic hold_both(input int grants, input int limit, output int g);
      int n = 0;
      g = 0;
      while (g < grants && n < limit) begin
         @(negedge clk);
         n++;
         if (gnt0 || gnt1) g++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g;
      rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      clear_mon();
      #1 rst_n = 1'b0;
      #1;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_gnt", {30'd0, gnt0, gnt1}, 32'd0);
      check("reset_owner", {31'd0, owner}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();

      // model pins
      check("model_frame_55", {21'd0, frame_of(8'h55)},
`ifdef UART_TX_PARITY_EN
            {21'd0, 11'b10010101010});
`else
            {21'd0, 11'b01010101010});
`endif
      check("model_frame_07", {21'd0, frame_of(8'h07)},
`ifdef UART_TX_PARITY_EN
            {21'd0, 11'b11000001110});
`else
            {21'd0, 11'b01000001110});
`endif

      // single 0x55 from requester 0
      @(negedge clk);
      req0 = 1'b1; data0 = 8'h55;
      wait_gnt(20);
      req0 = 1'b0;
      wait_idle(100);
      check("a_gnt0_cnt", gnt0_cnt, 1);
      check("a_gnt1_cnt", gnt1_cnt, 0);
      check("a_busy_len", len_q.size() > 0 ? len_q[0] : -1, NB * CD);
      check("a_frame", {21'd0, frame_q.size() > 0 ? frame_q[0] : 11'h7ff}, {21'd0, frame_of(8'h55)});
      check("a_owner", {31'd0, owner}, 32'd0);

      // both requesters held: alternating frames
      do_reset();
      req0 = 1'b1; data0 = 8'hA5; req1 = 1'b1; data1 = 8'h3C;
      hold_both(3, 400, g);
      check("b_grants", g, 3);
      wait_idle(100);
      check("b_owners", gnt_q.size() == 3 ? {gnt_q[0], gnt_q[1], gnt_q[2]} : 3'b111, 3'b010);
      check("b_gaps", gap_q.size() == 2 ? gap_q[0] * 16 + gap_q[1] : -1, 17);
      check("b_frame0", {21'd0, frame_q.size() == 3 ? frame_q[0] : 11'h7ff}, {21'd0, frame_of(8'hA5)});
      check("b_frame1", {21'd0, frame_q.size() == 3 ? frame_q[1] : 11'h7ff}, {21'd0, frame_of(8'h3C)});
      check("b_frame2", {21'd0, frame_q.size() == 3 ? frame_q[2] : 11'h7ff}, {21'd0, frame_of(8'hA5)});

      // requester 1 alone through three grants
      do_reset();
      req1 = 1'b1; data1 = 8'h96;
      hold_both(3, 400, g);
      check("c_grants", g, 3);
      wait_idle(100);
      check("c_gnt0_cnt", gnt0_cnt, 0);
      check("c_frames", len_q.size(), 3);
      for (int i = 0; i < len_q.size(); i++) check("c_len", len_q[i], NB * CD);
      check("c_gaps", gap_q.size() == 2 ? gap_q[0] * 16 + gap_q[1] : -1, 17);

      // reset during data bit 3 of 0xF0
      do_reset();
      req0 = 1'b1; data0 = 8'hF0;
      wait_gnt(20);
      req0 = 1'b0;
      repeat (CD * 4 + 1) @(negedge clk);
      check("d_pre_tx", {31'd0, tx}, 32'd0);
      check("d_pre_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("d_rst_tx", {31'd0, tx}, 32'd1);
      check("d_rst_busy", {31'd0, busy}, 32'd0);
      check("d_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
      req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      wait_gnt(20);
      check("d_first_gnt", {30'd0, gnt0, gnt1}, 32'd2);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle(100);

      // 0x07 frame length and content
      do_reset();
      req0 = 1'b1; data0 = 8'h07;
      wait_gnt(20);
      req0 = 1'b0;
      wait_idle(100);
`ifdef UART_TX_PARITY_EN
      check("e_len", len_q.size() > 0 ? len_q[0] : -1, 44);
`else
      check("e_len", len_q.size() > 0 ? len_q[0] : -1, 40);
`endif
      check("e_frame", {21'd0, frame_q.size() > 0 ? frame_q[0] : 11'h7ff}, {21'd0, frame_of(8'h07)});

      // withdrawn request during another frame
      do_reset();
      req1 = 1'b1; data1 = 8'h5A;
      wait_gnt(20);
      req1 = 1'b0;
      repeat (8) @(negedge clk);
      req0 = 1'b1; data0 = 8'hC3;
      repeat (5) @(negedge clk);
      req0 = 1'b0;
      wait_idle(100);
      repeat (20) @(negedge clk);
      check("f_gnt0_cnt", gnt0_cnt, 0);
      check("f_frames", len_q.size(), 1);
      check("f_tx_idle", {31'd0, tx}, 32'd1);
      check("f_busy", {31'd0, busy}, 32'd0);

      // randomized requesters
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (gnt0) begin
            req0 = 1'($urandom_range(0, 1));
            data0 = 8'($urandom);
         end else if (!req0) begin
            if ($urandom_range(0, 3) == 0) begin req0 = 1'b1; data0 = 8'($urandom); end
         end else if ($urandom_range(0, 31) == 0) req0 = 1'b0;
         if (gnt1) begin
            req1 = 1'($urandom_range(0, 1));
            data1 = 8'($urandom);
         end else if (!req1) begin
            if ($urandom_range(0, 3) == 0) begin req1 = 1'b1; data1 = 8'($urandom); end
         end else if ($urandom_range(0, 31) == 0) req1 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle(100);
      for (int i = 0; i < len_q.size(); i++) check("r_len", len_q[i], NB * CD);
      for (int i = 0; i < gap_q.size(); i++) check("r_gap_min", {31'd0, gap_q[i] >= 1}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
